// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: definitions shared by the sequence checker and the generator FSMs.
//   CODE_W      : width of one generator code
//   st_e        : checker FSM state encoding (ST_HUNT, ST_ACQ, ST_LOCKED)
//   SEQ_DEFAULT : default 6-entry cyclic code sequence. Entry i sits at [3i+2:3i],
//                 so the cycle runs 000,001,011,111,110,100.
package seq_chk_pkg;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } st_e;

  localparam logic [6*CODE_W-1:0] SEQ_DEFAULT =
    {3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
endpackage

// File: rtl/seq_checker_sat_counter.sv
// sat_counter: saturating up-counter with a synchronous clear.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   clr  : clear to zero; takes priority over inc
//   inc  : count up by one, holding at all-ones
//   cnt  : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst)                  cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && ~&cnt)     cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/seq_checker.sv
// seq_checker: receive-side monitor for a cyclic 3-bit code stream.
// It hunts for any code of SEQ, needs LOCK_CNT consecutive in-order samples to
// lock, then flags every mismatch while locked. It drops lock after MISS_MAX
// consecutive misses. All outputs are registered (one-cycle latency).
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   in_valid : in_code is sampled this cycle
//   in_code  : observed generator code
//   err_clr  : clear err_cnt (and good_cnt)
//   locked   : checker is in LOCKED
//   err      : one-cycle pulse on a mismatch while locked
//   err_cnt  : saturating count of mismatches while locked
//   phase    : index of the next expected code
//   good_cnt : (only with SEQ_CHK_STATS_EN) saturating count of matches while locked
module seq_checker
  import seq_chk_pkg::*;
#(
  parameter int                      SEQ_LEN  = 6,
  parameter logic [3*SEQ_LEN-1:0]    SEQ      = SEQ_DEFAULT,
  parameter int                      LOCK_CNT = 3,
  parameter int                      MISS_MAX = 2,
  parameter int                      CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  input  logic              err_clr,
  output logic              locked,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt,
`ifdef SEQ_CHK_STATS_EN
  output logic [CNT_W-1:0]  good_cnt,
`endif
  output logic [2:0]        phase
);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam logic [2:0] LAST = 3'(SEQ_LEN - 1);

  st_e                state, state_n;
  logic [2:0]         phase_n;
  logic [RUN_W-1:0]   run, run_n;
  logic [MISS_W-1:0]  miss, miss_n;
  logic               err_n, good_inc;

  // Code table padded to 8 entries so any 3-bit phase indexes it safely.
  logic [7:0][CODE_W-1:0] seq_tab;
  for (genvar g = 0; g < 8; g++) begin : g_tab
    if (g < SEQ_LEN) begin : g_used
      assign seq_tab[g] = SEQ[3*g +: 3];
    end else begin : g_pad
      assign seq_tab[g] = '0;
    end
  end

  // Lowest matching index wins: scan from the top down so low hits overwrite.
  logic       hit;
  logic [2:0] hit_idx;
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = SEQ_LEN - 1; i >= 0; i--) begin
      if (in_code == seq_tab[i]) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  logic [2:0] phase_inc, hit_nxt;
  logic       match;
  assign phase_inc = (phase == LAST)   ? 3'd0 : phase + 3'd1;
  assign hit_nxt   = (hit_idx == LAST) ? 3'd0 : hit_idx + 3'd1;
  assign match     = (in_code == seq_tab[phase]);

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    run_n    = run;
    miss_n   = miss;
    err_n    = 1'b0;
    good_inc = 1'b0;
    case (state)
      ST_HUNT: begin
        if (in_valid && hit) begin
          phase_n = hit_nxt;
          run_n   = RUN_W'(1);
          miss_n  = '0;
          state_n = (LOCK_CNT == 1) ? ST_LOCKED : ST_ACQ;
        end
      end
      ST_ACQ: begin
        if (in_valid) begin
          if (match) begin
            phase_n = phase_inc;
            run_n   = run + RUN_W'(1);
            if (run == RUN_W'(LOCK_CNT - 1)) begin
              state_n = ST_LOCKED;
              miss_n  = '0;
            end
          end else if (hit) begin
            // Restart acquisition from the offending sample itself.
            phase_n = hit_nxt;
            run_n   = RUN_W'(1);
            state_n = (LOCK_CNT == 1) ? ST_LOCKED : ST_ACQ;
          end else begin
            phase_n = '0;
            run_n   = '0;
            state_n = ST_HUNT;
          end
        end
      end
      ST_LOCKED: begin
        if (in_valid) begin
          // Flywheel: phase keeps advancing through mismatches.
          phase_n = phase_inc;
          if (match) begin
            miss_n   = '0;
            good_inc = 1'b1;
          end else begin
            err_n = 1'b1;
            if (miss == MISS_W'(MISS_MAX - 1)) begin
              state_n = ST_HUNT;
              phase_n = '0;
              run_n   = '0;
              miss_n  = '0;
            end else begin
              miss_n = miss + MISS_W'(1);
            end
          end
        end
      end
      default: begin
        state_n = ST_HUNT;
        phase_n = '0;
        run_n   = '0;
        miss_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_HUNT;
      phase <= '0;
      run   <= '0;
      miss  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      run   <= run_n;
      miss  <= miss_n;
      err   <= err_n;
    end
  end

  assign locked = (state == ST_LOCKED);

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (err_clr),
    .inc (err_n),
    .cnt (err_cnt)
  );

`ifdef SEQ_CHK_STATS_EN
  sat_counter #(.W(CNT_W)) u_good_cnt (
    .clk (clk),
    .rst (rst),
    .clr (err_clr),
    .inc (good_inc),
    .cnt (good_cnt)
  );
`else
  logic unused_good;
  assign unused_good = good_inc;
`endif
endmodule
